// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: FSM states, default geometry, lane width helper.
// No logic or state lives in this package.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    localparam int MSBD_DEF         = 3;
    localparam int WORDS_DEF        = 4;
    localparam int MSBC_DEF         = 1;
    localparam int FLUSH_CYCLES_DEF = 8;

    function automatic int lane_width(input int msbd);
        return msbd + 1;
    endfunction

    localparam int LANE_W_DEF = MSBD_DEF + 1;

endpackage

// File: rtl/fifo_packer_flush_timer.sv
// Idle timer: counts enabled cycles and pulses expired on the FLUSH_CYCLES-th one.
// Expired is combinational from enable; the count restarts on clear or on expiry.
module fifo_packer_flush_timer #(
    parameter int FLUSH_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(FLUSH_CYCLES + 1);

    logic [W-1:0] idle;

    // Fire on the edge that would bring the idle count to FLUSH_CYCLES.
    assign expired = enable & (idle == W'(FLUSH_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle <= '0;
        end else if (clear || expired) begin
            idle <= '0;
        end else if (enable) begin
            idle <= idle + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a FIFO and packs WORDS words into one valid/ready output word (lane 0 = first popped);
// valid rises on the edge capturing the last lane, no pops while a word is held. Partial flush: PACKER_FLUSH_EN.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int MSBD         = MSBD_DEF,
    parameter int WORDS        = WORDS_DEF,
    parameter int MSBC         = MSBC_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MSBD:0]               fifoData,
    input  logic                        fifoEmpty,
    input  logic                        fifoFull,
    input  logic                        fifoPush,
    output logic                        fifoPop,
    output logic [(MSBD+1)*WORDS-1:0]   outData,
    output logic [MSBC:0]               outLanes,
    output logic                        outValid,
    input  logic                        outReady
);

    localparam int            LW         = lane_width(MSBD);
    localparam logic [MSBC:0] LAST_LANE  = (MSBC+1)'(WORDS - 1);
    // When WORDS == 2^(MSBC+1) a full word wraps to 0 here; widen MSBC to see the true count.
    localparam logic [MSBC:0] FULL_LANES = (MSBC+1)'(WORDS);

    pack_state_t   state, state_nxt;
    logic [MSBC:0] count;
    logic          accepted;
    logic          last_lane;
    logic          flush;

    assign fifoPop   = (state == FILL) & ~fifoEmpty & reset_n;
    // The FIFO lets an effective push win over a pop, so that pop never happened.
    assign accepted  = fifoPop & ~(fifoPush & ~fifoFull);
    assign last_lane = accepted & (count == LAST_LANE);

`ifdef PACKER_FLUSH_EN
    logic idle_en;

    assign idle_en = (state == FILL) & (count != '0) & ~accepted;

    fifo_packer_flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (~idle_en),
        .enable  (idle_en),
        .expired (flush)
    );
`else
    // Partial words wait for more data; the flush interval has no effect in this build.
    assign flush = 1'b0 & (FLUSH_CYCLES != 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_lane || flush) state_nxt = HOLD;
            HOLD:    if (outReady)           state_nxt = FILL;
            default:                         state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            outData  <= '0;
            outLanes <= '0;
            outValid <= 1'b0;
        end else begin
            if (accepted) begin
                outData[count*LW +: LW] <= fifoData;
                count <= last_lane ? '0 : count + 1'b1;
            end else if (flush) begin
                count <= '0;
            end

            if (last_lane) begin
                outValid <= 1'b1;
                outLanes <= FULL_LANES;
            end else if (flush) begin
                outValid <= 1'b1;
                outLanes <= count;
            end else if (state == HOLD && outReady) begin
                outValid <= 1'b0;
                outData  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized checks of fifo_word_packer against a FIFO model and a word-stream scoreboard.
module tb_fifo_word_packer;

    localparam int MSBD  = 3;
    localparam int WORDS = 4;
    localparam int MSBC  = 2;
    localparam int DEPTH = 16;
    localparam int DW    = (MSBD+1)*WORDS;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [MSBD:0] fifoData;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          fifoPush = 1'b0;
    logic          fifoPop;
    logic [DW-1:0] outData;
    logic [MSBC:0] outLanes;
    logic          outValid;
    logic          outReady = 1'b0;

    logic [MSBD:0] pushData = '0;
    logic          fifo_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fifo_word_packer #(
        .MSBD         (MSBD),
        .WORDS        (WORDS),
        .MSBC         (MSBC),
        .FLUSH_CYCLES (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .fifoData  (fifoData),
        .fifoEmpty (fifoEmpty),
        .fifoFull  (fifoFull),
        .fifoPush  (fifoPush),
        .fifoPop   (fifoPop),
        .outData   (outData),
        .outLanes  (outLanes),
        .outValid  (outValid),
        .outReady  (outReady)
    );

    // FIFO model: push has priority over pop unless full; contents survive packer reset.
    logic [MSBD:0] mem [DEPTH];
    logic [3:0]    rd = '0;
    logic [3:0]    wr = '0;
    int            cnt = 0;
    logic          push_eff;
    logic          pop_eff;
    logic [MSBD:0] stream [$];

    assign fifoData  = mem[rd];
    assign fifoEmpty = (cnt == 0);
    assign fifoFull  = (cnt == DEPTH);

    always @(posedge clock) begin
        if (fifo_clr) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= 0;
            stream.delete();
        end else begin
            push_eff = fifoPush && (cnt < DEPTH);
            pop_eff  = fifoPop && !push_eff && (cnt > 0);
            if (push_eff) begin
                mem[wr] <= pushData;
                wr      <= wr + 1'b1;
                stream.push_back(pushData);
            end
            if (pop_eff) rd <= rd + 1'b1;
            cnt <= cnt + (push_eff ? 1 : 0) - (pop_eff ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the packer in reset, empty the FIFO, then push n words base, base+1, ...
    task automatic preload(input int n, input int base);
        reset_n  = 1'b0;
        fifoPush = 1'b0;
        fifo_clr = 1'b1;
        @(negedge clock);
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            fifoPush = 1'b1;
            pushData = 4'((base + i) & 15);
            @(negedge clock);
        end
        fifoPush = 1'b0;
    endtask

    // Count cycles (and pop requests) until outValid is seen at a falling edge.
    task automatic wait_valid(output int n, output int pops);
        n = 0;
        pops = 0;
        do begin
            #1;
            pops += int'(fifoPop);
            @(negedge clock);
            n++;
        end while (!outValid && n < 40);
    endtask

    initial begin
        int n, pops, hs, saw;
        logic [DW-1:0] exp;

        // Basic pack
        preload(4, 1);
        outReady = 1'b1;
        #1;
        chk("rst_valid", outValid, 0);
        chk("rst_lanes", outLanes, 0);
        chk("rst_data", outData, 0);
        chk("rst_pop", fifoPop, 0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_valid(n, pops);
        chk("basic_latency", n, 4);
        chk("basic_pops", pops, 4);
        chk("basic_data", outData, 16'h4321);
        chk("basic_lanes", outLanes, 4);
        chk("basic_hold_pop", fifoPop, 0);
        @(negedge clock);
        chk("basic_pulse", outValid, 0);
        chk("basic_clear", outData, 0);

        // Backpressure
        preload(8, 1);
        outReady = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_valid(n, pops);
        chk("bp_first", outData, 16'h4321);
        repeat (5) @(negedge clock);
        chk("bp_held_data", outData, 16'h4321);
        chk("bp_held_valid", outValid, 1);
        chk("bp_no_pop", fifoPop, 0);
        outReady = 1'b1;
        wait_valid(n, pops);
        chk("bp_second_cycles", n, WORDS + 1);
        chk("bp_second_data", outData, 16'h8765);

        // Push collision: pop dropped, capture retried next cycle
        preload(4, 1);
        outReady = 1'b1;
        @(negedge clock);
        reset_n  = 1'b1;
        fifoPush = 1'b1;
        pushData = 4'h9;
        @(negedge clock);
        fifoPush = 1'b0;
        chk("coll_no_capture", outData, 0);
        wait_valid(n, pops);
        chk("coll_latency", n, 4);
        chk("coll_data", outData, 16'h4321);

        // Push on a full FIFO: pop accepted
        preload(16, 1);
        outReady = 1'b1;
        @(negedge clock);
        reset_n  = 1'b1;
        fifoPush = 1'b1;
        pushData = 4'hE;
        @(negedge clock);
        fifoPush = 1'b0;
        chk("full_capture", outData, 16'h0001);
        wait_valid(n, pops);
        chk("full_latency", n, 3);
        chk("full_data", outData, 16'h4321);

        // Reset mid-word
        preload(8, 1);
        outReady = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_partial", outData, 16'h0021);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", outValid, 0);
        chk("midrst_data", outData, 0);
        chk("midrst_pop", fifoPop, 0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_valid(n, pops);
        chk("midrst_latency", n, 4);
        chk("midrst_data_new", outData, 16'h6543);
        chk("midrst_lanes", outLanes, 4);

        // Partial word with FIFO running dry
        preload(3, 10);
        outReady = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
`ifdef PACKER_FLUSH_EN
        wait_valid(n, pops);
        chk("flush_cycles", n, 3 + 8);
        chk("flush_lanes", outLanes, 3);
        chk("flush_data", outData, 16'h0CBA);
`else
        saw = 0;
        repeat (20) begin
            @(negedge clock);
            if (outValid) saw = 1;
        end
        chk("noflush_valid", saw, 0);
        chk("noflush_partial", outData, 16'h0CBA);
        chk("noflush_pop", fifoPop, 0);
`endif

        // Randomized traffic against the pushed-word stream
        preload(0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        hs = 0;
        for (int c = 0; c < 800; c++) begin
            fifoPush = ($urandom_range(0, 3) != 0);
            pushData = 4'($urandom_range(0, 15));
            outReady = $urandom_range(0, 1) == 1;
            #1;
            if (outValid && outReady) begin
                chk("rand_avail", stream.size() >= WORDS, 1);
                if (stream.size() >= WORDS) begin
                    for (int i = 0; i < WORDS; i++) exp[i*(MSBD+1) +: MSBD+1] = stream.pop_front();
                    chk("rand_data", outData, exp);
                    chk("rand_lanes", outLanes, WORDS);
                end
                hs++;
            end
            @(negedge clock);
        end
        fifoPush = 1'b0;
        chk("rand_handshakes", hs > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
